// File: rtl/sap_control_unit_if.sv
// Control-unit bundle: sequencing inputs from IR/flags plus every datapath strobe.
interface sap_control_unit_if #(parameter int T_W = 3);
  logic [3:0]     opcode;
  logic           flag_z;
  logic           flag_c;
  logic           hold;
  logic           pc_inc;
  logic           pc_oe;
  logic           pc_load;
  logic           mar_write;
  logic           ram_oe;
  logic           ram_write;
  logic           ir_write;
  logic           ir_oe;
  logic           a_write;
  logic           a_oe;
  logic           b_write;
  logic           alu_oe;
  logic           alu_sub;
  logic           flags_write;
  logic           out_write;
  logic           halted;
  logic           instr_done;
  logic [T_W-1:0] t_state;

  modport master (
    output opcode, flag_z, flag_c, hold,
    input  pc_inc, pc_oe, pc_load, mar_write, ram_oe, ram_write, ir_write, ir_oe,
           a_write, a_oe, b_write, alu_oe, alu_sub, flags_write, out_write,
           halted, instr_done, t_state
  );

  modport slave (
    input  opcode, flag_z, flag_c, hold,
    output pc_inc, pc_oe, pc_load, mar_write, ram_oe, ram_write, ir_write, ir_oe,
           a_write, a_oe, b_write, alu_oe, alu_sub, flags_write, out_write,
           halted, instr_done, t_state
  );
endinterface

// File: rtl/sap_control_unit.sv
// SAP microsequencer: T-state counter, halt flag and combinational strobe decode.
module sap_control_unit #(
  parameter int T_W = 3
) (
  input logic                clk,
  input logic                rst,
  sap_control_unit_if.slave  bus
);

  typedef enum logic [T_W-1:0] {
    T0 = T_W'(0),
    T1 = T_W'(1),
    T2 = T_W'(2),
    T3 = T_W'(3),
    T4 = T_W'(4)
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JZ  = 4'h7, OP_JC  = 4'h8,
                         OP_OUT = 4'hE, OP_HLT = 4'hF;

  typedef struct packed {
    logic pc_inc, pc_oe, pc_load, mar_write, ram_oe, ram_write, ir_write, ir_oe;
    logic a_write, a_oe, b_write, alu_oe, alu_sub, flags_write, out_write;
  } strobe_t;

  t_state_e t_q, t_d;
  logic     halt_q, halt_d;
  strobe_t  st;
  logic     done;

  always_comb begin
    st   = '0;
    done = 1'b0;
    case (t_q)
      T0: begin st.pc_oe = 1'b1; st.mar_write = 1'b1; end
      T1: begin st.ram_oe = 1'b1; st.ir_write = 1'b1; st.pc_inc = 1'b1; end
      T2: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin st.ir_oe = 1'b1; st.mar_write = 1'b1; end
          OP_LDI: begin st.ir_oe = 1'b1; st.a_write = 1'b1; done = 1'b1; end
          OP_JMP: begin st.ir_oe = 1'b1; st.pc_load = 1'b1; done = 1'b1; end
          OP_JZ:  begin st.ir_oe = bus.flag_z; st.pc_load = bus.flag_z; done = 1'b1; end
          OP_JC:  begin st.ir_oe = bus.flag_c; st.pc_load = bus.flag_c; done = 1'b1; end
          OP_OUT: begin st.a_oe = 1'b1; st.out_write = 1'b1; done = 1'b1; end
          default: done = 1'b1;
        endcase
      end
      T3: begin
        case (bus.opcode)
          OP_LDA: begin st.ram_oe = 1'b1; st.a_write = 1'b1; done = 1'b1; end
          OP_ADD, OP_SUB: begin st.ram_oe = 1'b1; st.b_write = 1'b1; end
          OP_STA: begin st.a_oe = 1'b1; st.ram_write = 1'b1; done = 1'b1; end
          default: done = 1'b1;
        endcase
      end
      T4: begin
        if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
          st.alu_oe      = 1'b1;
          st.a_write     = 1'b1;
          st.flags_write = 1'b1;
          st.alu_sub     = (bus.opcode == OP_SUB);
        end
        done = 1'b1;
      end
      default: done = 1'b1;
    endcase
    // rst gating makes strobes drop the instant reset asserts, not at the next edge
    if (!rst || halt_q || bus.hold) begin
      st   = '0;
      done = 1'b0;
    end
  end

  always_comb begin
    t_d    = t_q;
    halt_d = halt_q;
    if (halt_q) begin
      t_d = T0;
    end else if (!bus.hold) begin
      if (done) begin
        t_d = T0;
        if (t_q == T2 && bus.opcode == OP_HLT) halt_d = 1'b1;
      end else begin
        t_d = t_state_e'(t_q + T_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_q    <= T0;
      halt_q <= 1'b0;
    end else begin
      t_q    <= t_d;
      halt_q <= halt_d;
    end
  end

  assign bus.pc_inc      = st.pc_inc;
  assign bus.pc_oe       = st.pc_oe;
  assign bus.pc_load     = st.pc_load;
  assign bus.mar_write   = st.mar_write;
  assign bus.ram_oe      = st.ram_oe;
  assign bus.ram_write   = st.ram_write;
  assign bus.ir_write    = st.ir_write;
  assign bus.ir_oe       = st.ir_oe;
  assign bus.a_write     = st.a_write;
  assign bus.a_oe        = st.a_oe;
  assign bus.b_write     = st.b_write;
  assign bus.alu_oe      = st.alu_oe;
  assign bus.alu_sub     = st.alu_sub;
  assign bus.flags_write = st.flags_write;
  assign bus.out_write   = st.out_write;
  assign bus.halted      = halt_q;
  assign bus.instr_done  = done;
  assign bus.t_state     = t_q;

endmodule

// File: tb/tb_sap_control_unit.sv
// Bench for sap_control_unit: directed vector table, multi-cycle corner cases, random vs micro-program model.
module tb_sap_control_unit;
  localparam int T_W = 3;

  localparam logic [14:0] S_PC_INC = 15'h4000, S_PC_OE  = 15'h2000, S_PC_LD  = 15'h1000,
                          S_MAR_W  = 15'h0800, S_RAM_OE = 15'h0400, S_RAM_W  = 15'h0200,
                          S_IR_W   = 15'h0100, S_IR_OE  = 15'h0080, S_A_W    = 15'h0040,
                          S_A_OE   = 15'h0020, S_B_W    = 15'h0010, S_ALU_OE = 15'h0008,
                          S_ALU_SUB= 15'h0004, S_FLG_W  = 15'h0002, S_OUT_W  = 15'h0001;
  localparam logic [14:0] FETCH0 = S_PC_OE | S_MAR_W;
  localparam logic [14:0] FETCH1 = S_RAM_OE | S_IR_W | S_PC_INC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  sap_control_unit_if #(.T_W(T_W)) bus ();

  sap_control_unit #(.T_W(T_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [14:0] act_s;
  assign act_s = {bus.pc_inc, bus.pc_oe, bus.pc_load, bus.mar_write, bus.ram_oe, bus.ram_write,
                  bus.ir_write, bus.ir_oe, bus.a_write, bus.a_oe, bus.b_write, bus.alu_oe,
                  bus.alu_sub, bus.flags_write, bus.out_write};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [14:0] es, input logic ed,
                         input int et, input logic eh);
    chk({tag, ".strobes"}, 32'(act_s), 32'(es));
    chk({tag, ".done"}, 32'(bus.instr_done), 32'(ed));
    chk({tag, ".t_state"}, 32'(bus.t_state), 32'(et));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(eh));
  endtask

  // Drive one cycle's inputs just after the falling edge, settle, leave the rising edge to come.
  task automatic drive(input logic r, input logic [3:0] op, input logic z, input logic c,
                       input logic h);
    @(negedge clk);
    rst = r; bus.opcode = op; bus.flag_z = z; bus.flag_c = c; bus.hold = h;
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  op;
    logic        z, c, h;
    logic [14:0] s;
    logic        d;
    int          t;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic r, input logic [3:0] op, input logic z, input logic c,
                     input logic h, input logic [14:0] s, input logic d, input int t);
    vec_t v;
    v.r = r; v.op = op; v.z = z; v.c = c; v.h = h; v.s = s; v.d = d; v.t = t;
    vt.push_back(v);
  endtask

  // Reference model: each opcode is a micro-program of strobe words indexed by step.
  logic [14:0] uprog[16][5];
  int          ulen[16];
  int          ucond[16];  // 0 none, 1 needs Z, 2 needs C
  int          m_step;
  bit          m_halt;

  task automatic build_model();
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 5; k++) uprog[op][k] = '0;
      uprog[op][0] = FETCH0;
      uprog[op][1] = FETCH1;
      ulen[op] = 3;
      ucond[op] = 0;
    end
    uprog[1][2] = S_IR_OE | S_MAR_W; uprog[1][3] = S_RAM_OE | S_A_W; ulen[1] = 4;
    for (int op = 2; op <= 3; op++) begin
      uprog[op][2] = S_IR_OE | S_MAR_W; uprog[op][3] = S_RAM_OE | S_B_W;
      uprog[op][4] = S_ALU_OE | S_A_W | S_FLG_W | ((op == 3) ? S_ALU_SUB : 15'h0);
      ulen[op] = 5;
    end
    uprog[4][2] = S_IR_OE | S_MAR_W; uprog[4][3] = S_A_OE | S_RAM_W; ulen[4] = 4;
    uprog[5][2] = S_IR_OE | S_A_W;
    uprog[6][2] = S_IR_OE | S_PC_LD;
    uprog[7][2] = S_IR_OE | S_PC_LD; ucond[7] = 1;
    uprog[8][2] = S_IR_OE | S_PC_LD; ucond[8] = 2;
    uprog[14][2] = S_A_OE | S_OUT_W;
  endtask

  task automatic model_cycle(input logic r, input logic [3:0] op, input logic z, input logic c,
                             input logic h);
    logic [14:0] es;
    logic        ed;
    int          et;
    es = '0; ed = 1'b0; et = m_step;
    if (!r) et = 0;
    else if (m_halt) et = 0;
    else if (!h) begin
      es = uprog[op][m_step];
      if ((ucond[op] == 1 && !z) || (ucond[op] == 2 && !c)) if (m_step == 2) es = '0;
      ed = (m_step == ulen[op] - 1);
    end
    chk_all("rand", es, ed, et, r ? m_halt : 1'b0);
    if (!r) begin
      m_step = 0; m_halt = 0;
    end else if (!m_halt && !h) begin
      if (ed) begin
        m_step = 0;
        if (op == 4'hF) m_halt = 1;
      end else m_step++;
    end
  endtask

  initial begin
    bus.opcode = 4'h0; bus.flag_z = 1'b0; bus.flag_c = 1'b0; bus.hold = 1'b0;

    // reset, fetch, ADD, JZ taken / not taken, LDA with hold at T3, SUB
    add(0, 4'h2, 0, 0, 0, 15'h0, 0, 0);
    add(1, 4'h2, 0, 0, 0, FETCH0, 0, 0);
    add(1, 4'h2, 0, 0, 0, FETCH1, 0, 1);
    add(1, 4'h2, 0, 0, 0, S_IR_OE | S_MAR_W, 0, 2);
    add(1, 4'h2, 0, 0, 0, S_RAM_OE | S_B_W, 0, 3);
    add(1, 4'h2, 0, 0, 0, S_ALU_OE | S_A_W | S_FLG_W, 1, 4);
    add(1, 4'h7, 1, 0, 0, FETCH0, 0, 0);
    add(1, 4'h7, 1, 0, 0, FETCH1, 0, 1);
    add(1, 4'h7, 1, 0, 0, S_IR_OE | S_PC_LD, 1, 2);
    add(1, 4'h7, 0, 1, 0, FETCH0, 0, 0);
    add(1, 4'h7, 0, 1, 0, FETCH1, 0, 1);
    add(1, 4'h7, 0, 1, 0, 15'h0, 1, 2);
    add(1, 4'h1, 0, 0, 0, FETCH0, 0, 0);
    add(1, 4'h1, 0, 0, 0, FETCH1, 0, 1);
    add(1, 4'h1, 0, 0, 0, S_IR_OE | S_MAR_W, 0, 2);
    add(1, 4'h1, 0, 0, 1, 15'h0, 0, 3);
    add(1, 4'h1, 0, 0, 1, 15'h0, 0, 3);
    add(1, 4'h1, 0, 0, 1, 15'h0, 0, 3);
    add(1, 4'h1, 0, 0, 0, S_RAM_OE | S_A_W, 1, 3);
    add(1, 4'h3, 0, 0, 0, FETCH0, 0, 0);
    add(1, 4'h3, 0, 0, 0, FETCH1, 0, 1);
    add(1, 4'h3, 0, 0, 0, S_IR_OE | S_MAR_W, 0, 2);
    add(1, 4'h3, 0, 0, 0, S_RAM_OE | S_B_W, 0, 3);
    add(1, 4'h3, 0, 0, 0, S_ALU_OE | S_A_W | S_FLG_W | S_ALU_SUB, 1, 4);
    add(1, 4'h8, 0, 1, 0, FETCH0, 0, 0);
    add(1, 4'h8, 0, 1, 0, FETCH1, 0, 1);
    add(1, 4'h8, 0, 1, 0, S_IR_OE | S_PC_LD, 1, 2);

    #2 rst = 1'b0;
    foreach (vt[i]) begin
      drive(vt[i].r, vt[i].op, vt[i].z, vt[i].c, vt[i].h);
      chk_all($sformatf("vec%0d", i), vt[i].s, vt[i].d, vt[i].t, 1'b0);
    end

    // HLT: halted sticks through hold toggling; only reset clears it
    drive(1, 4'hF, 0, 0, 0); chk_all("hlt.t0", FETCH0, 0, 0, 0);
    drive(1, 4'hF, 0, 0, 0); chk_all("hlt.t1", FETCH1, 0, 1, 0);
    drive(1, 4'hF, 0, 0, 0); chk_all("hlt.t2", 15'h0, 1, 2, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 4'(i), i[0], i[1], i[0]);
      chk_all($sformatf("halted%0d", i), 15'h0, 0, 0, 1);
    end
    drive(0, 4'h0, 0, 0, 0); chk_all("hlt.rst", 15'h0, 0, 0, 0);
    drive(1, 4'h0, 0, 0, 0); chk_all("hlt.refetch0", FETCH0, 0, 0, 0);
    drive(1, 4'h0, 0, 0, 0); chk_all("hlt.refetch1", FETCH1, 0, 1, 0);
    drive(1, 4'h0, 0, 0, 0); chk_all("hlt.nop", 15'h0, 1, 2, 0);

    // STA aborted by reset asserted between edges during T3
    drive(1, 4'h4, 0, 0, 0); chk_all("sta.t0", FETCH0, 0, 0, 0);
    drive(1, 4'h4, 0, 0, 0); chk_all("sta.t1", FETCH1, 0, 1, 0);
    drive(1, 4'h4, 0, 0, 0); chk_all("sta.t2", S_IR_OE | S_MAR_W, 0, 2, 0);
    drive(1, 4'h4, 0, 0, 0); chk_all("sta.t3", S_A_OE | S_RAM_W, 1, 3, 0);
    #1 rst = 1'b0;
    #1 chk_all("sta.abort", 15'h0, 0, 0, 0);
    drive(1, 4'h4, 0, 0, 0); chk_all("sta.after0", FETCH0, 0, 0, 0);
    drive(1, 4'h4, 0, 0, 0); chk_all("sta.after1", FETCH1, 0, 1, 0);

    // random phase against the micro-program model
    build_model();
    m_step = 0; m_halt = 0;
    drive(0, 4'h0, 0, 0, 0); model_cycle(0, 4'h0, 0, 0, 0);
    begin
      logic [3:0] op;
      int         halt_cnt;
      op = 4'h0; halt_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
        logic r, z, c, h;
        if (m_step == 0) op = 4'($urandom_range(0, 15));
        z = 1'($urandom); c = 1'($urandom);
        h = ($urandom_range(0, 3) == 0);
        halt_cnt = m_halt ? halt_cnt + 1 : 0;
        r = !((halt_cnt > 4) || ($urandom_range(0, 199) == 0));
        drive(r, op, z, c, h);
        model_cycle(r, op, z, c, h);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
Microsequencer for the 16-bit SAP datapath. It steps a T-state counter through fetch (PC→MAR, RAM→IR, PC++) and then an opcode-dependent execute sequence. It drives every bus-enable and register-write strobe, including ir_write and the IR operand enable. The opcode comes from IR bits [15:12]; the operand address/immediate is IR [11:0] and is placed on the bus by the IR when ir_oe=1.

Parameters:
T_W, 3, width of the t_state counter (values 0..4 used)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
opcode  input  4  IR[15:12]
flag_z  input  1  zero flag from the flags register
flag_c  input  1  carry flag from the flags register
hold  input  1  freeze sequencing (memory busy or single-step)
pc_inc  output  1  program counter increment
pc_oe  output  1  PC drives bus
pc_load  output  1  PC loads from bus
mar_write  output  1  MAR loads from bus
ram_oe  output  1  RAM drives bus
ram_write  output  1  RAM writes bus at MAR
ir_write  output  1  IR loads from bus
ir_oe  output  1  IR[11:0] drives bus (zero-extended)
a_write  output  1  A register loads from bus
a_oe  output  1  A drives bus
b_write  output  1  B register loads from bus
alu_oe  output  1  ALU result drives bus
alu_sub  output  1  ALU subtracts (1) or adds (0)
flags_write  output  1  flags register captures ALU flags
out_write  output  1  output register loads from bus
halted  output  1  HLT executed
instr_done  output  1  last cycle of the current instruction
t_state  output  T_W  current T-state

Behaviour:
- State: t_state register plus halt flag. All strobes are combinational from (t_state, opcode, flags, hold, halt). At most one bus driver is asserted per cycle.
- Reset (rst=0, asynchronous): t_state=0, halted=0. While rst=0, every strobe and instr_done is 0. Reset asserted mid-instruction aborts it; the first cycle after release is T0.
- hold=1: t_state frozen; all strobes and instr_done are 0. Sequencing resumes at the same T-state when hold=0.
- T0: pc_oe, mar_write.
- T1: ram_oe, ir_write, pc_inc. The opcode is valid from T2.
- T2..T4 execute:
  - LDA 0x1: T2 ir_oe+mar_write; T3 ram_oe+a_write (done).
  - ADD 0x2: T2 ir_oe+mar_write; T3 ram_oe+b_write; T4 alu_oe+a_write+flags_write (done).
  - SUB 0x3: as ADD, with alu_sub=1 at T4.
  - STA 0x4: T2 ir_oe+mar_write; T3 a_oe+ram_write (done).
  - LDI 0x5: T2 ir_oe+a_write (done).
  - JMP 0x6: T2 ir_oe+pc_load (done).
  - JZ 0x7 / JC 0x8: T2 ir_oe+pc_load only if flag_z / flag_c is 1, otherwise no strobes; done at T2 in both cases.
  - OUT 0xE: T2 a_oe+out_write (done).
  - HLT 0xF: T2 no strobes, instr_done=1; halt flag sets.
  - NOP 0x0 and undefined opcodes: T2 no strobes (done).
- Sequencing: instr_done=1 in an instruction's final execute cycle. The next t_state is 0 after a done cycle, otherwise t_state+1. t_state never exceeds 4.
- Halt: halted=1 from the cycle after HLT's T2. While halted, t_state holds at 0, all strobes are 0 and hold is ignored. Only rst clears halt.
- Flags are sampled combinationally in T2 of JZ/JC. A flag change in that same cycle is used.

Test Plan:
- Reset/idle: rst=0 with clk running → all strobes 0, t_state=0; after release, T0 shows pc_oe=1 and mar_write=1, T1 shows ram_oe=1, ir_write=1, pc_inc=1.
- ADD (opcode=0x2): strobe sequence T2 ir_oe+mar_write, T3 ram_oe+b_write, T4 alu_oe+a_write+flags_write with alu_sub=0; instr_done only at T4; next cycle t_state=0.
- JZ (opcode=0x7): flag_z=1 → T2 ir_oe=1 and pc_load=1; flag_z=0 → T2 all strobes 0; instr_done=1 at T2 in both cases.
- hold: hold=1 asserted at T3 of LDA for 3 cycles → t_state stays 3, strobes 0; after release, ram_oe+a_write fire once and instr_done=1.
- HLT (opcode=0xF): halted=1 from the next cycle; 20 further cycles with hold toggling → t_state=0 and no strobes; rst pulse → halted=0 and fetch restarts.
- Reset mid-op: rst=0 asserted asynchronously during T3 of STA (between clock edges) → ram_write drops immediately; after release, T0 fetch begins with no ram_write.
